// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter:
// RV funct3 encodings, arbiter FSM states and the access-size helper.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_IF = 2'd1,
    RSP_LS = 2'd2
  } arb_state_t;

  // Access size in bytes; 0 marks an encoding with no legal size (funct3 = 111).
  function automatic logic [3:0] access_size_f(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size_f = 4'd1;
      F3_H, F3_HU: access_size_f = 4'd2;
      F3_W, F3_WU: access_size_f = 4'd4;
      F3_D:        access_size_f = 4'd8;
      default:     access_size_f = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (IF, LSU), the arbiter and the data memory.
// Handshake: a request transfers in the cycle where *_req_valid & *_req_ready are both 1;
// a requester that sees ready = 0 keeps valid and its request fields stable. Responses
// are single-cycle pulses one cycle after the transfer and cannot be back-pressured.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 15,
  parameter int DATA_W = 64
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              if_rsp_err;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_we;
  logic [2:0]        ls_req_funct3;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              ls_rsp_err;

  logic [MEM_AW-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_byte_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    output mem_addr, mem_wr_en, mem_byte_en, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output ls_req_valid, ls_req_we, ls_req_funct3, ls_req_addr, ls_req_wdata,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    input  mem_addr, mem_wr_en, mem_byte_en, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for a 64-bit memory word: from the low address bits and funct3
// it produces byte enables, the misalignment flag, lane-shifted store data and the
// extracted, sign/zero-extended load data. Purely combinational.
module mem_lane_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  input  logic [63:0] rd_data,
  output logic [7:0]  byte_en,
  output logic        misaligned,
  output logic [63:0] wr_data,
  output logic [63:0] rd_ext
);

  logic [3:0]  size;
  logic [7:0]  mask;
  logic [63:0] rd_sh;
  logic        sgn;

  // Size decode, alignment test, lane shifts and load extension.
  always_comb begin
    size = access_size_f(funct3);
    case (size)
      4'd1:    mask = 8'h01;
      4'd2:    mask = 8'h03;
      4'd4:    mask = 8'h0F;
      4'd8:    mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    // size-1 over three bits is 7 for doublewords, so the low-bit test covers every size.
    misaligned = (size == 4'd0) || ((addr_lo & (size[2:0] - 3'd1)) != 3'd0);
    byte_en    = misaligned ? 8'h00 : (mask << addr_lo);
    wr_data    = wdata << {addr_lo, 3'b000};
    rd_sh      = rd_data >> {addr_lo, 3'b000};
    // Unsigned variants (BU/HU/WU) all have funct3[2] set.
    sgn        = ~funct3[2];
    case (size)
      4'd1:    rd_ext = {{56{sgn & rd_sh[7]}},  rd_sh[7:0]};
      4'd2:    rd_ext = {{48{sgn & rd_sh[15]}}, rd_sh[15:0]};
      4'd4:    rd_ext = {{32{sgn & rd_sh[31]}}, rd_sh[31:0]};
      default: rd_ext = rd_sh;
    endcase
    if (misaligned) rd_ext = 64'd0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between instruction fetch and the LSU.
// Memory reads are asynchronous and writes synchronous, so every access is issued
// in its accept cycle and answered by a registered pulse one cycle later.
// Build option MEM_ARB_RR_EN: round-robin arbitration on simultaneous requests;
// without it the LSU has fixed priority over fetch.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 15,
  parameter int DATA_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_port_arbiter_if.slave bus,
  output arb_state_t   state_dbg
);

  logic              gnt_if;
  logic              gnt_ls;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_f3;
  logic [7:0]        al_be;
  logic              al_mis;
  logic [63:0]       al_wr_data;
  logic [63:0]       al_rd_ext;
  logic              unused_addr_hi;

  arb_state_t        state;
  logic              if_rsp_valid_q;
  logic [31:0]       if_rsp_data_q;
  logic              if_rsp_err_q;
  logic              ls_rsp_valid_q;
  logic [63:0]       ls_rsp_data_q;
  logic              ls_rsp_err_q;

`ifdef MEM_ARB_RR_EN
  logic rr_last_ls;  // 1 = most recent accept went to the LSU

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (!rst) begin
      if (bus.ls_req_valid && bus.if_req_valid) begin
        gnt_if = rr_last_ls;
        gnt_ls = ~rr_last_ls;
      end else begin
        gnt_ls = bus.ls_req_valid;
        gnt_if = bus.if_req_valid;
      end
    end
  end
`else
  // Fixed-priority grant: fetch only wins when the LSU is silent. Nothing is granted in reset.
  always_comb begin
    gnt_ls = ~rst & bus.ls_req_valid;
    gnt_if = ~rst & bus.if_req_valid & ~bus.ls_req_valid;
  end
`endif

  // Steer the winning request into the lane aligner; a fetch is an unsigned word access.
  always_comb begin
    sel_addr = gnt_if ? bus.if_req_addr : bus.ls_req_addr;
    sel_f3   = gnt_if ? F3_WU : bus.ls_req_funct3;
  end

  mem_lane_align u_align (
    .addr_lo    (sel_addr[2:0]),
    .funct3     (sel_f3),
    .wdata      (bus.ls_req_wdata),
    .rd_data    (bus.mem_rd_data),
    .byte_en    (al_be),
    .misaligned (al_mis),
    .wr_data    (al_wr_data),
    .rd_ext     (al_rd_ext)
  );

  // Address bits above the memory size simply wrap.
  assign unused_addr_hi   = ^sel_addr[ADDR_W-1:MEM_AW];

  assign bus.if_req_ready = gnt_if;
  assign bus.ls_req_ready = gnt_ls;
  assign bus.mem_addr     = {sel_addr[MEM_AW-1:3], 3'b000};
  assign bus.mem_byte_en  = (gnt_if | gnt_ls) ? al_be : 8'h00;
  assign bus.mem_wr_en    = gnt_ls & bus.ls_req_we & ~al_mis;
  assign bus.mem_wr_data  = al_wr_data;

  // Arbiter FSM with the response registers: capture the access result for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= 32'd0;
      if_rsp_err_q   <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_data_q  <= 64'd0;
      ls_rsp_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_ls     <= 1'b1;
`endif
    end else begin
      if (gnt_if)      state <= RSP_IF;
      else if (gnt_ls) state <= RSP_LS;
      else             state <= IDLE;
      if_rsp_valid_q <= gnt_if;
      if_rsp_err_q   <= gnt_if & al_mis;
      if_rsp_data_q  <= gnt_if ? al_rd_ext[31:0] : 32'd0;
      ls_rsp_valid_q <= gnt_ls;
      ls_rsp_err_q   <= gnt_ls & al_mis;
      ls_rsp_data_q  <= (gnt_ls && !bus.ls_req_we) ? al_rd_ext : 64'd0;
`ifdef MEM_ARB_RR_EN
      if (gnt_if | gnt_ls) rr_last_ls <= gnt_ls;
`endif
    end
  end

  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.if_rsp_err   = if_rsp_err_q;
  assign bus.ls_rsp_valid = ls_rsp_valid_q;
  assign bus.ls_rsp_data  = ls_rsp_data_q;
  assign bus.ls_rsp_err   = ls_rsp_err_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 4096 x 64-bit memory
// (async read, byte-enabled sync write). Inputs change on the falling edge,
// outputs are sampled 1 time unit after it.
module tb_mem_port_arbiter;
  import rv32i_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_t state_dbg;

  mem_port_arbiter_if #(.ADDR_W(32), .MEM_AW(15), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .MEM_AW(15), .DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [63:0] mem [0:4095];

  always_comb bus.mem_rd_data = mem[bus.mem_addr[14:3]];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      for (int b = 0; b < 8; b++)
        if (bus.mem_byte_en[b]) mem[bus.mem_addr[14:3]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic        s_rdy, s_we, s_rv, s_err;
  logic [7:0]  s_be;
  logic [63:0] s_wd, s_rd;
  logic [14:0] s_ma;

  task automatic idle_inputs();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.ls_req_valid  = 1'b0;
    bus.ls_req_we     = 1'b0;
    bus.ls_req_funct3 = 3'b000;
    bus.ls_req_addr   = '0;
    bus.ls_req_wdata  = '0;
  endtask

  task automatic ls_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd);
    @(negedge clk);
    bus.ls_req_valid  = 1'b1;
    bus.ls_req_we     = we;
    bus.ls_req_funct3 = f3;
    bus.ls_req_addr   = addr;
    bus.ls_req_wdata  = wd;
    #1;
    s_rdy = bus.ls_req_ready;
    s_be  = bus.mem_byte_en;
    s_we  = bus.mem_wr_en;
    s_wd  = bus.mem_wr_data;
    s_ma  = bus.mem_addr;
    @(negedge clk);
    bus.ls_req_valid = 1'b0;
    #1;
    s_rv  = bus.ls_rsp_valid;
    s_rd  = bus.ls_rsp_data;
    s_err = bus.ls_rsp_err;
  endtask

  task automatic if_op(input logic [31:0] addr);
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = addr;
    #1;
    s_rdy = bus.if_req_ready;
    s_be  = bus.mem_byte_en;
    s_we  = bus.mem_wr_en;
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    #1;
    s_rv  = bus.if_rsp_valid;
    s_rd  = {32'd0, bus.if_rsp_data};
    s_err = bus.if_rsp_err;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] exp_g;
  logic [1:0] prev_g;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ls_rsp_valid", bus.ls_rsp_valid, 0);
    check("rst_if_rsp_valid", bus.if_rsp_valid, 0);
    check("rst_ls_rsp_err",   bus.ls_rsp_err, 0);
    check("rst_ls_rsp_data",  bus.ls_rsp_data, 0);
    check("rst_if_rsp_data",  bus.if_rsp_data, 0);
    check("rst_byte_en",      bus.mem_byte_en, 0);
    check("rst_state",        state_dbg, IDLE);

    // SD then LD at 0
    ls_op(1'b1, F3_D, 32'h0, 64'h1122334455667788);
    check("sd_ready",   s_rdy, 1);
    check("sd_byte_en", s_be, 8'hFF);
    check("sd_wr_en",   s_we, 1);
    check("sd_rsp_valid", s_rv, 1);
    check("sd_rsp_data",  s_rd, 0);
    ls_op(1'b0, F3_D, 32'h0, 64'h0);
    check("ld_byte_en",   s_be, 8'hFF);
    check("ld_wr_en",     s_we, 0);
    check("ld_rsp_valid", s_rv, 1);
    check("ld_rsp_data",  s_rd, 64'h1122334455667788);
    check("ld_rsp_err",   s_err, 0);

    // fetches
    if_op(32'h4);
    check("if4_ready", s_rdy, 1);
    check("if4_valid", s_rv, 1);
    check("if4_data",  s_rd, 64'h11223344);
    if_op(32'h0);
    check("if0_data",  s_rd, 64'h55667788);
    if_op(32'h2);
    check("if2_valid",   s_rv, 1);
    check("if2_err",     s_err, 1);
    check("if2_data",    s_rd, 0);
    check("if2_byte_en", s_be, 0);

    // byte loads, sign handling
    ls_op(1'b0, F3_B, 32'h3, 64'h0);
    check("lb3_data", s_rd, 64'h55);
    ls_op(1'b1, F3_B, 32'h8, 64'h80);
    check("sb8_byte_en", s_be, 8'h01);
    ls_op(1'b0, F3_BU, 32'h8, 64'h0);
    check("lbu8_data", s_rd, 64'h80);
    ls_op(1'b0, F3_B, 32'h8, 64'h0);
    check("lb8_data", s_rd, 64'hFFFFFFFFFFFFFF80);

    // halfword store, misaligned accesses
    ls_op(1'b1, F3_H, 32'h6, 64'hBEEF);
    check("sh6_byte_en", s_be, 8'hC0);
    check("sh6_wdata_hi", s_wd[63:48], 16'hBEEF);
    ls_op(1'b0, F3_H, 32'h5, 64'h0);
    check("lh5_valid",   s_rv, 1);
    check("lh5_err",     s_err, 1);
    check("lh5_data",    s_rd, 0);
    check("lh5_byte_en", s_be, 0);
    ls_op(1'b1, F3_W, 32'h2, 64'hFFFFFFFF);
    check("sw2_wr_en", s_we, 0);
    check("sw2_err",   s_err, 1);
    ls_op(1'b0, F3_D, 32'h0, 64'h0);
    check("ld0_after_sh", s_rd, 64'hBEEF334455667788);
    ls_op(1'b0, F3_W, 32'h4, 64'h0);
    check("lw4_data", s_rd, 64'hFFFFFFFFBEEF3344);
    ls_op(1'b0, F3_WU, 32'h4, 64'h0);
    check("lwu4_data", s_rd, 64'h00000000BEEF3344);
    ls_op(1'b0, 3'b111, 32'h0, 64'h0);
    check("f3_111_err", s_err, 1);
    check("f3_111_data", s_rd, 0);
    ls_op(1'b0, F3_D, 32'h8000, 64'h0);
    check("wrap_mem_addr", s_ma, 0);
    check("wrap_data", s_rd, 64'hBEEF334455667788);

    // contention: both requesters valid for four cycles; exp = {ls_ready, if_ready}
`ifdef MEM_ARB_RR_EN
    if_op(32'h0);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
`else
    repeat (4) exp_q.push_back(2'b10);
`endif
    @(negedge clk);
    bus.ls_req_valid  = 1'b1;
    bus.ls_req_we     = 1'b0;
    bus.ls_req_funct3 = F3_D;
    bus.ls_req_addr   = 32'h0;
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h0;
    prev_g = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g = exp_q.pop_front();
      check("arb_grant", {bus.ls_req_ready, bus.if_req_ready}, exp_g);
      if (k > 0) begin
        check("arb_ls_rsp", bus.ls_rsp_valid, prev_g[1]);
        check("arb_if_rsp", bus.if_rsp_valid, prev_g[0]);
      end
      prev_g = exp_g;
      @(negedge clk);
    end
    idle_inputs();

    // reset asserted in the cycle a store is presented
    @(negedge clk);
    rst = 1'b1;
    bus.ls_req_valid  = 1'b1;
    bus.ls_req_we     = 1'b1;
    bus.ls_req_funct3 = F3_D;
    bus.ls_req_addr   = 32'h10;
    bus.ls_req_wdata  = 64'hDEADBEEFCAFEF00D;
    #1;
    check("rst_acc_ready", bus.ls_req_ready, 0);
    check("rst_acc_wr_en", bus.mem_wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("post_rst_ls_valid", bus.ls_rsp_valid, 0);
    check("post_rst_if_valid", bus.if_rsp_valid, 0);
    check("post_rst_ls_data",  bus.ls_rsp_data, 0);
    check("post_rst_byte_en",  bus.mem_byte_en, 0);
    check("post_rst_wr_en",    bus.mem_wr_en, 0);
    check("post_rst_state",    state_dbg, IDLE);
    check("post_rst_mem",      mem[2], 0);
    ls_op(1'b0, F3_D, 32'h10, 64'h0);
    check("post_rst_ld10", s_rd, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
